uart_tx_arbiter: RTL and testbench

- Bus-master front end that shares the single UART transmit peripheral between NUM_REQ byte-stream requesters, e.g. core console and debug/trace.
- After reset it configures the peripheral: baud divider at offset 0x8, then tx enable at 0x0.
- It then serves requesters round-robin. For each byte it polls STATUS (0x4) bit[0] until idle, then writes TXDATA (0xC).
- Sits between the requesters and the peripheral's we/req/addr/data/data_o slave port.

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit peripheral between NUM_REQ
// byte-stream requesters. Configures baud/enable after reset, then serves
// requesters round-robin: poll STATUS until idle, then write TXDATA.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       per-requester byte valid
//   req_data_i        requester k byte at [8k+7:8k]
//   req_ready_o       one-hot accept (transfer on valid & ready)
//   uart_req_o/we_o   peripheral access strobe / write enable
//   uart_addr_o       peripheral address (BASE_ADDR + offset)
//   uart_data_o       peripheral write data
//   uart_data_i       peripheral read data (STATUS bit0 = tx busy)
//   init_done_o       configuration writes complete
//   busy_o            a byte is held (polling or writing)
//   tx_count_o        bytes written to TXDATA, wraps at 16 bits
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] BAUD_DIV  = 32'h1B8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 uart_req_o,
    output logic                 uart_we_o,
    output logic [31:0]          uart_addr_o,
    output logic [31:0]          uart_data_o,
    input  logic [31:0]          uart_data_i,
    output logic                 init_done_o,
    output logic                 busy_o,
    output logic [15:0]          tx_count_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

    localparam logic [31:0] OFF_CTRL   = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_BAUD   = 32'h8;
    localparam logic [31:0] OFF_TXDATA = 32'hC;

    typedef enum logic [2:0] {
        S_INIT_BAUD,
        S_INIT_CTRL,
        S_IDLE,
        S_POLL,
        S_WRITE
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [7:0]    held;

    logic          gnt_found;
    logic [IW-1:0] gnt_idx;
    logic [7:0]    gnt_data;
    logic [IW-1:0] rr_next;
    logic [IW:0]   sum;
    logic [IW-1:0] jx;
    logic [IW:0]   nxt;

    // Only the busy flag of STATUS is meaningful here.
    logic unused_status;
    assign unused_status = ^uart_data_i[31:1];

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_data  = '0;
        sum       = '0;
        jx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= NR)
                sum = sum - NR;
            jx = sum[IW-1:0];
            if (!gnt_found && req_valid_i[jx]) begin
                gnt_found = 1'b1;
                gnt_idx   = jx;
                gnt_data  = req_data_i[{jx, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        nxt = {1'b0, gnt_idx} + (IW+1)'(1);
        if (nxt == NR)
            nxt = '0;
        rr_next = nxt[IW-1:0];
    end

    always_comb begin
        req_ready_o = '0;
        if (!rst && state == S_IDLE && gnt_found)
            req_ready_o[gnt_idx] = 1'b1;
    end

    always_comb begin
        uart_req_o  = 1'b0;
        uart_we_o   = 1'b0;
        uart_addr_o = '0;
        uart_data_o = '0;
        if (!rst) begin
            unique case (state)
                S_INIT_BAUD: begin
                    uart_req_o  = 1'b1;
                    uart_we_o   = 1'b1;
                    uart_addr_o = BASE_ADDR + OFF_BAUD;
                    uart_data_o = BAUD_DIV;
                end
                S_INIT_CTRL: begin
                    uart_req_o  = 1'b1;
                    uart_we_o   = 1'b1;
                    uart_addr_o = BASE_ADDR + OFF_CTRL;
                    uart_data_o = 32'h1;
                end
                S_IDLE: begin
                    uart_addr_o = BASE_ADDR + OFF_STATUS;
                end
                S_POLL: begin
                    uart_req_o  = 1'b1;
                    uart_addr_o = BASE_ADDR + OFF_STATUS;
                end
                S_WRITE: begin
                    uart_req_o  = 1'b1;
                    uart_we_o   = 1'b1;
                    uart_addr_o = BASE_ADDR + OFF_TXDATA;
                    uart_data_o = {24'h0, held};
                end
                default: ;
            endcase
        end
    end

    assign busy_o = !rst && (state == S_POLL || state == S_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT_BAUD;
            rr_ptr      <= '0;
            tx_count_o  <= '0;
            init_done_o <= 1'b0;
            held        <= '0;
        end else begin
            unique case (state)
                S_INIT_BAUD: state <= S_INIT_CTRL;
                S_INIT_CTRL: begin
                    state       <= S_IDLE;
                    init_done_o <= 1'b1;
                end
                S_IDLE: begin
                    if (gnt_found) begin
                        held   <= gnt_data;
                        rr_ptr <= rr_next;
                        state  <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (!uart_data_i[0])
                        state <= S_WRITE;
                end
                S_WRITE: begin
                    tx_count_o <= tx_count_o + 16'd1;
                    state      <= S_IDLE;
                end
                default: state <= S_INIT_BAUD;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized bench for uart_tx_arbiter
// with a queue-based requester/peripheral reference model.
module tb_uart_tx_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rst_next;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           uart_req;
    logic           uart_we;
    logic [31:0]    uart_addr;
    logic [31:0]    uart_wdata;
    logic [31:0]    uart_rdata;
    logic           init_done;
    logic           busy;
    logic [15:0]    tx_count;

    logic [30:0]    stat_hi;
    int             busy_cnt;
    int             busy_len;
    int             gap_en;

    always #5 clk = ~clk;

    assign uart_rdata = {stat_hi, busy_cnt != 0};

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .uart_req_o  (uart_req),
        .uart_we_o   (uart_we),
        .uart_addr_o (uart_addr),
        .uart_data_o (uart_wdata),
        .uart_data_i (uart_rdata),
        .init_done_o (init_done),
        .busy_o      (busy),
        .tx_count_o  (tx_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  rq [N][$];
    logic [7:0]  sb[$];
    logic [7:0]  wlog[$];
    int          model_ptr;
    logic [15:0] model_count;
    logic [N-1:0] acc_mask;
    logic        wr_seen;
    int          expg;
    int          gotg;
    int          idx;

    always @(negedge clk) begin
        acc_mask = '0;
        wr_seen  = 1'b0;
        if (rst) begin
            sb.delete();
            model_ptr   = 0;
            model_count = 16'h0;
        end else begin
            if (req_ready != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                check("ready_valid", 32'(req_ready & ~req_valid), 0);
            end
            acc_mask = req_valid & req_ready;
            if (acc_mask != '0) begin
                expg = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (model_ptr + k) % N;
                    if (expg < 0 && req_valid[idx])
                        expg = idx;
                end
                gotg = 0;
                for (int k = 0; k < N; k++)
                    if (acc_mask[k]) gotg = k;
                check("rr_grant", gotg, expg);
                sb.push_back(req_data[8*gotg +: 8]);
                model_ptr = (gotg + 1) % N;
            end
            if (uart_req && uart_we && uart_addr == 32'hC) begin
                wr_seen = 1'b1;
                check("write_idle", busy_cnt, 0);
                check("tx_count", 32'(tx_count), 32'(model_count));
                if (sb.size() == 0)
                    check("write_unexpected", 1, 0);
                else
                    check("tx_data", uart_wdata, {24'h0, sb.pop_front()});
                wlog.push_back(uart_wdata[7:0]);
                model_count = model_count + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst = rst_next;
        for (int k = 0; k < N; k++)
            if (acc_mask[k]) void'(rq[k].pop_front());
        if (wr_seen) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        if (gap_en != 0) busy_len = $urandom_range(6);
        stat_hi = 31'($urandom);
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (rq[k].size() != 0) &&
                           (gap_en == 0 || $urandom_range(3) != 0);
            req_data[8*k +: 8] = (rq[k].size() != 0) ? rq[k][0] : 8'h0;
        end
    endtask

    task automatic step();
        tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wlog(input int n, input int max);
        int c = 0;
        while (wlog.size() < n && c < max) begin
            step();
            c++;
        end
        if (wlog.size() < n)
            check("timeout", wlog.size(), n);
    endtask

    task automatic check_init(input string tag);
        check({tag, "_c0_req"}, 32'(uart_req), 1);
        check({tag, "_c0_we"}, 32'(uart_we), 1);
        check({tag, "_c0_addr"}, uart_addr, 32'h8);
        check({tag, "_c0_data"}, uart_wdata, 32'h1B8);
        check({tag, "_c0_done"}, 32'(init_done), 0);
        step();
        check({tag, "_c1_we"}, 32'(uart_we), 1);
        check({tag, "_c1_addr"}, uart_addr, 32'h0);
        check({tag, "_c1_data"}, uart_wdata, 32'h1);
        step();
        check({tag, "_c2_done"}, 32'(init_done), 1);
        check({tag, "_c2_ready"}, 32'(req_ready), 0);
        check({tag, "_c2_req"}, 32'(uart_req), 0);
    endtask

    int n0;
    int polls;

    initial begin
        rst_next  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        stat_hi   = '0;
        busy_cnt  = 0;
        busy_len  = 0;
        gap_en    = 0;
        acc_mask  = '0;
        wr_seen   = 1'b0;

        repeat (3) step();
        check("rst_req", 32'(uart_req), 0);
        check("rst_we", 32'(uart_we), 0);
        check("rst_addr", uart_addr, 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_done", 32'(init_done), 0);
        check("rst_count", 32'(tx_count), 0);

        rst_next = 1'b0;
        step();
        check_init("init");

        // Single byte, peripheral idle: write two cycles after accept
        rq[0].push_back(8'h55);
        step();
        check("sb_ready", 32'(req_ready), 32'b01);
        step();
        check("sb_poll_req", 32'(uart_req), 1);
        check("sb_poll_we", 32'(uart_we), 0);
        check("sb_poll_addr", uart_addr, 32'h4);
        check("sb_poll_ready", 32'(req_ready), 0);
        check("sb_busy", 32'(busy), 1);
        step();
        check("sb_wr_addr", uart_addr, 32'hC);
        check("sb_wr_data", uart_wdata, 32'h55);
        step();
        check("sb_count", 32'(tx_count), 1);

        // Peripheral busy for 10 status cycles
        rq[0].push_back(8'hA3);
        busy_cnt = 11;
        polls = 0;
        n0 = wlog.size();
        for (int c = 0; c < 40 && wlog.size() == n0; c++) begin
            step();
            if (uart_req && !uart_we && uart_addr == 32'h4) polls++;
        end
        check("busy_polls", polls, 10);
        check("busy_nwr", wlog.size(), n0 + 1);
        if (wlog.size() > n0)
            check("busy_data", 32'(wlog[n0]), 32'hA3);
        step();

        // Requester 1 single byte so the pointer returns to 0
        n0 = wlog.size();
        rq[1].push_back(8'h5A);
        wait_wlog(n0 + 1, 20);
        step();
        step();

        // Round robin with both requesters continuously valid
        n0 = wlog.size();
        for (int i = 0; i < 4; i++) begin
            rq[0].push_back(8'h11);
            rq[1].push_back(8'h22);
        end
        wait_wlog(n0 + 8, 100);
        for (int i = 0; i < 8 && n0 + i < wlog.size(); i++)
            check("rr_order", 32'(wlog[n0+i]), (i % 2 == 0) ? 32'h11 : 32'h22);
        step();
        step();

        // Reset while holding a byte in the poll loop
        busy_cnt = 1000;
        rq[0].push_back(8'h7E);
        for (int c = 0; c < 10 && !(uart_req && !uart_we); c++)
            step();
        check("rm_in_poll", 32'(busy), 1);
        n0 = wlog.size();
        rst_next = 1'b1;
        step();
        check("rm_req", 32'(uart_req), 0);
        check("rm_ready", 32'(req_ready), 0);
        step();
        check("rm_count", 32'(tx_count), 0);
        check("rm_done", 32'(init_done), 0);
        busy_cnt = 0;
        rst_next = 1'b0;
        step();
        check_init("rm");
        repeat (5) step();
        check("rm_nowrite", wlog.size(), n0);

        // Counter wrap
        force dut.tx_count_o = 16'hFFFF;
        step();
        release dut.tx_count_o;
        model_count = 16'hFFFF;
        check("wrap_pre", 32'(tx_count), 32'hFFFF);
        n0 = wlog.size();
        rq[1].push_back(8'h3C);
        wait_wlog(n0 + 1, 20);
        step();
        check("wrap_post", 32'(tx_count), 0);

        // Randomized traffic with gaps and random peripheral busy time
        gap_en = 1;
        n0 = wlog.size();
        for (int i = 0; i < 60; i++)
            rq[$urandom_range(N-1)].push_back(8'($urandom));
        wait_wlog(n0 + 60, 3000);
        gap_en = 0;
        busy_len = 0;
        repeat (10) step();
        check("rand_drain", sb.size(), 0);
        check("final_count", 32'(tx_count), 32'(model_count));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
